// File: rtl/axi_defs.sv
// Shared AXI3 definitions for the on-chip RAM responder: widths, response
// and burst codes, FSM state constants and small address/response helpers.
package axi_defs;

    localparam int unsigned ID_W   = 32'd4;
    localparam int unsigned DATA_W = 32'd32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Next beat address: FIXED stays put, WRAP is served as INCR.
    function automatic logic [31:0] addr_advance(input logic [31:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
        logic [31:0] nxt;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = addr + (32'd1 << size);
            BURST_WRAP:  nxt = addr + (32'd1 << size);
            default:     nxt = addr + (32'd1 << size);
        endcase
        return nxt;
    endfunction

    // Response codes are ordered so that the numerically larger code wins:
    // DECERR > SLVERR > OKAY.
    function automatic logic [1:0] resp_merge(input logic [1:0] a,
                                              input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Word array behind the AXI RAM responder: one asynchronous read port and
// one synchronous byte-enabled write port. Contents are never reset.
module axi_ram_mem
    import axi_defs::*;
#(
    parameter int unsigned MEM_WORDS = 32'd1024,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        wr_be
);

    logic [DATA_W-1:0] mem_r [MEM_WORDS];

    assign rd_data = mem_r[rd_idx];

    // Byte-lane write; a concurrent read of the same word still sees old data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_be[0]) mem_r[wr_idx][7:0]   <= wr_data[7:0];
            if (wr_be[1]) mem_r[wr_idx][15:8]  <= wr_data[15:8];
            if (wr_be[2]) mem_r[wr_idx][23:16] <= wr_data[23:16];
            if (wr_be[3]) mem_r[wr_idx][31:24] <= wr_data[31:24];
        end
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave RAM responder with independent read and write state machines,
// per-beat address decode, sticky burst error reporting and an optional
// fixed wait before every read beat.
module axi_ram_slave
    import axi_defs::*;
#(
    parameter int unsigned MEM_WORDS  = 32'd1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned READ_DELAY = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  DLY_INIT  = (READ_DELAY > 32'd0) ? 4'(READ_DELAY - 32'd1) : 4'd0;

    // True when the byte address falls inside the mapped window
    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < MEM_BYTES);
    endfunction

    // Word index of a byte address, truncated to the array depth
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // AXI3 write id is not used for reordering; writes are served in order
    logic wid_unused_s;
    assign wid_unused_s = ^wid;

    // Read side state
    logic [1:0]        r_state_r;
    logic              arready_r, rvalid_r, rlast_r;
    logic [ID_W-1:0]   rid_r;
    logic [DATA_W-1:0] rdata_r;
    logic [1:0]        rresp_r;
    logic [31:0]       raddr_r;
    logic [7:0]        rlen_r, rbeat_r;
    logic [2:0]        rsize_r;
    logic [1:0]        rburst_r;
    logic [3:0]        rdly_r;

    // Write side state
    logic [1:0]        w_state_r;
    logic              awready_r, wready_r, bvalid_r;
    logic [ID_W-1:0]   awid_r, bid_r;
    logic [1:0]        bresp_r, werr_r;
    logic [31:0]       waddr_r;
    logic [3:0]        wlen_r;
    logic [2:0]        wsize_r;
    logic [1:0]        wburst_r;
    logic [7:0]        wbeat_r;

    // Combinational helpers
    logic [31:0]       raddr_next_s, rd_addr_s;
    logic [2:0]        rd_size_s;
    logic [DATA_W-1:0] mem_rdata_s, beat_data_s;
    logic [1:0]        beat_resp_s;
    logic              w_hs_s, wbeat_ok_s, mem_we_s;
    logic [1:0]        wbeat_resp_s, wresp_next_s;

    axi_ram_mem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rd_idx  (word_idx(rd_addr_s)),
        .rd_data (mem_rdata_s),
        .wr_en   (mem_we_s),
        .wr_idx  (word_idx(waddr_r)),
        .wr_data (wdata),
        .wr_be   (wstrb)
    );

    // Pick the address of the read beat that may be loaded at the next edge
    always_comb begin
        raddr_next_s = addr_advance(raddr_r, rsize_r, rburst_r);
        if (r_state_r == R_IDLE) begin
            rd_addr_s = araddr;
            rd_size_s = arsize;
        end else if (r_state_r == R_DATA) begin
            rd_addr_s = raddr_next_s;
            rd_size_s = rsize_r;
        end else begin
            rd_addr_s = raddr_r;
            rd_size_s = rsize_r;
        end
    end

    // Decode that beat into data and response; errored beats return zero data
    always_comb begin
        if (!in_range(rd_addr_s)) begin
            beat_resp_s = RESP_DECERR;
            beat_data_s = 32'h0000_0000;
        end else if (rd_size_s > 3'd2) begin
            beat_resp_s = RESP_SLVERR;
            beat_data_s = 32'h0000_0000;
        end else begin
            beat_resp_s = RESP_OKAY;
            beat_data_s = mem_rdata_s;
        end
    end

    // Read FSM: accept AR, optionally wait, then present beats until rlast
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= 4'd0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
            raddr_r   <= 32'h0000_0000;
            rlen_r    <= 8'd0;
            rsize_r   <= 3'd0;
            rburst_r  <= BURST_FIXED;
            rbeat_r   <= 8'd0;
            rdly_r    <= 4'd0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (arvalid && arready_r) begin
                        arready_r <= 1'b0;
                        rid_r     <= arid;
                        raddr_r   <= araddr;
                        rlen_r    <= arlen;
                        rsize_r   <= arsize;
                        rburst_r  <= arburst;
                        rbeat_r   <= 8'd0;
                        if (READ_DELAY > 32'd0) begin
                            r_state_r <= R_WAIT;
                            rdly_r    <= DLY_INIT;
                        end else begin
                            r_state_r <= R_DATA;
                            rvalid_r  <= 1'b1;
                            rdata_r   <= beat_data_s;
                            rresp_r   <= beat_resp_s;
                            rlast_r   <= (arlen == 8'd0);
                        end
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rdly_r == 4'd0) begin
                        r_state_r <= R_DATA;
                        rvalid_r  <= 1'b1;
                        rdata_r   <= beat_data_s;
                        rresp_r   <= beat_resp_s;
                        rlast_r   <= (rbeat_r == rlen_r);
                    end else begin
                        rdly_r <= rdly_r - 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_r) begin
                            r_state_r <= R_IDLE;
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                        end else begin
                            raddr_r <= raddr_next_s;
                            rbeat_r <= rbeat_r + 8'd1;
                            if (READ_DELAY > 32'd0) begin
                                r_state_r <= R_WAIT;
                                rvalid_r  <= 1'b0;
                                rdly_r    <= DLY_INIT;
                            end else begin
                                rdata_r <= beat_data_s;
                                rresp_r <= beat_resp_s;
                                rlast_r <= ((rbeat_r + 8'd1) == rlen_r);
                            end
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                    arready_r <= 1'b0;
                end
            endcase
        end
    end

    // Classify the current W beat and fold it into the sticky burst response
    always_comb begin
        w_hs_s     = (w_state_r == W_DATA) && wvalid && wready_r;
        wbeat_ok_s = (wbeat_r <= {4'd0, wlen_r});
        if (!wbeat_ok_s) begin
            wbeat_resp_s = RESP_OKAY;
        end else if (!in_range(waddr_r)) begin
            wbeat_resp_s = RESP_DECERR;
        end else if (wsize_r > 3'd2) begin
            wbeat_resp_s = RESP_SLVERR;
        end else begin
            wbeat_resp_s = RESP_OKAY;
        end
        if (wlast && (wbeat_r != {4'd0, wlen_r})) begin
            wresp_next_s = resp_merge(resp_merge(werr_r, wbeat_resp_s), RESP_SLVERR);
        end else begin
            wresp_next_s = resp_merge(werr_r, wbeat_resp_s);
        end
        mem_we_s = w_hs_s && wbeat_ok_s && in_range(waddr_r) && (wsize_r <= 3'd2);
    end

    // Write FSM: accept AW, absorb W beats until wlast, then hold B
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= 4'd0;
            bresp_r   <= RESP_OKAY;
            awid_r    <= 4'd0;
            werr_r    <= RESP_OKAY;
            waddr_r   <= 32'h0000_0000;
            wlen_r    <= 4'd0;
            wsize_r   <= 3'd0;
            wburst_r  <= BURST_FIXED;
            wbeat_r   <= 8'd0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (awvalid && awready_r) begin
                        w_state_r <= W_DATA;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        awid_r    <= awid;
                        waddr_r   <= awaddr;
                        wlen_r    <= awlen;
                        wsize_r   <= awsize;
                        wburst_r  <= awburst;
                        wbeat_r   <= 8'd0;
                        werr_r    <= RESP_OKAY;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        waddr_r <= addr_advance(waddr_r, wsize_r, wburst_r);
                        wbeat_r <= (wbeat_r == 8'hFF) ? wbeat_r : (wbeat_r + 8'd1);
                        werr_r  <= wresp_next_s;
                        if (wlast) begin
                            w_state_r <= W_RESP;
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= wresp_next_s;
                            bid_r     <= awid_r;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state_r <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rlast   = rlast_r;
    assign rid     = rid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bid     = bid_r;
    assign bresp   = bresp_r;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave: a zero-wait instance drives most of
// the traffic, a READ_DELAY=3 instance shares the write channel so its array
// holds the same contents. Expectations come from a word-array model updated
// with the AXI burst/strobe/decode rules.
module tb_axi_ram_slave;

    localparam int          MW   = 256;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  arid = '0;    logic [31:0] araddr = '0;  logic [7:0] arlen = '0;
    logic [2:0]  arsize = '0;  logic [1:0]  arburst = '0;
    logic        arv = 1'b0, rrdy = 1'b0, rsel = 1'b0;
    logic [3:0]  awid = '0;    logic [31:0] awaddr = '0;  logic [3:0] awlen = '0;
    logic [2:0]  awsize = '0;  logic [1:0]  awburst = '0; logic awvalid = 1'b0;
    logic [3:0]  wid = '0;     logic [31:0] wdata = '0;   logic [3:0] wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;

    logic arvalid0, arvalid1, rready0, rready1;
    assign arvalid0 = arv & ~rsel;
    assign arvalid1 = arv & rsel;
    assign rready0  = rrdy & ~rsel;
    assign rready1  = rrdy & rsel;

    logic        arready0, rvalid0, rlast0, awready0, wready0, bvalid0;
    logic [3:0]  rid0, bid0;
    logic [31:0] rdata0;
    logic [1:0]  rresp0, bresp0;
    logic        arready1, rvalid1, rlast1;
    logic [3:0]  rid1;
    logic [31:0] rdata1;
    logic [1:0]  rresp1;
    logic        d1_awready_unused, d1_wready_unused, d1_bvalid_unused;
    logic [3:0]  d1_bid_unused;
    logic [1:0]  d1_bresp_unused;

    axi_ram_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .READ_DELAY(0)) dut0 (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid0), .arready(arready0),
        .rid(rid0), .rdata(rdata0), .rresp(rresp0), .rlast(rlast0), .rvalid(rvalid0), .rready(rready0),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready0),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready0),
        .bid(bid0), .bresp(bresp0), .bvalid(bvalid0), .bready(bready)
    );

    axi_ram_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .READ_DELAY(3)) dut1 (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid1), .arready(arready1),
        .rid(rid1), .rdata(rdata1), .rresp(rresp1), .rlast(rlast1), .rvalid(rvalid1), .rready(rready1),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(d1_awready_unused),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(d1_wready_unused),
        .bid(d1_bid_unused), .bresp(d1_bresp_unused), .bvalid(d1_bvalid_unused), .bready(bready)
    );

    logic        o_arready, o_rvalid, o_rlast;
    logic [3:0]  o_rid;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    assign o_arready = rsel ? arready1 : arready0;
    assign o_rvalid  = rsel ? rvalid1  : rvalid0;
    assign o_rlast   = rsel ? rlast1   : rlast0;
    assign o_rid     = rsel ? rid1     : rid0;
    assign o_rdata   = rsel ? rdata1   : rdata0;
    assign o_rresp   = rsel ? rresp1   : rresp0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [MW];
    logic [31:0] wbuf_d [32];
    logic [3:0]  wbuf_s [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input longint a);
        return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * MW);
    endfunction

    function automatic longint beat_addr(input longint a, input int i, input int size, input int burst);
        return (burst == 0) ? a : a + longint'(i) * (longint'(1) << size);
    endfunction

    task automatic exp_beat(input longint a, input int size, output logic [31:0] d, output logic [1:0] r);
        if (!in_rng(a)) begin
            d = 32'h0; r = 2'b11;
        end else if (size > 2) begin
            d = 32'h0; r = 2'b10;
        end else begin
            d = model[int'((a - longint'(BASE)) >> 2)]; r = 2'b00;
        end
    endtask

    // One AW + W burst (wlast on beat last_idx) + B, with the model updated
    task automatic do_write(input longint addr, input int len, input int size, input int burst,
                            input int last_idx, input logic [3:0] id);
        int cyc;
        bit dec, slv;
        longint a;
        int idx;
        awid = id; awaddr = addr[31:0]; awlen = len[3:0]; awsize = size[2:0]; awburst = burst[1:0];
        awvalid = 1'b1;
        wid = id; wdata = wbuf_d[0]; wstrb = wbuf_s[0]; wlast = (last_idx == 0); wvalid = 1'b1;
        cyc = 0;
        while (!awready0 && cyc < 100) begin tick(); cyc++; end
        chk("aw_timeout", 32'(cyc >= 100), 32'd0);
        chk("w_before_aw", 32'(wready0), 32'd0);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= last_idx; i++) begin
            wdata = wbuf_d[i]; wstrb = wbuf_s[i]; wlast = (i == last_idx); wvalid = 1'b1;
            cyc = 0;
            while (!wready0 && cyc < 100) begin tick(); cyc++; end
            chk("w_timeout", 32'(cyc >= 100), 32'd0);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        dec = 1'b0;
        slv = (size > 2) || (last_idx != len);
        for (int i = 0; i <= last_idx && i <= len; i++) begin
            a = beat_addr(addr, i, size, burst);
            if (!in_rng(a)) begin
                dec = 1'b1;
            end else if (size <= 2) begin
                idx = int'((a - longint'(BASE)) >> 2);
                for (int b = 0; b < 4; b++)
                    if (wbuf_s[i][b]) model[idx][8*b +: 8] = wbuf_d[i][8*b +: 8];
            end
        end
        bready = 1'b1;
        cyc = 0;
        while (!bvalid0 && cyc < 100) begin tick(); cyc++; end
        chk("b_timeout", 32'(cyc >= 100), 32'd0);
        chk("bresp", 32'(bresp0), dec ? 32'd3 : (slv ? 32'd2 : 32'd0));
        chk("bid", 32'(bid0), 32'(id));
        tick();
        bready = 1'b0;
        chk("b_release", 32'(bvalid0), 32'd0);
        chk("aw_reassert", 32'(awready0), 32'd1);
    endtask

    // One AR burst; mode 0 random rready, 1 alternating 1/0, 2 always ready
    task automatic do_read(input bit sel, input longint addr, input int len, input int size,
                           input int burst, input logic [3:0] id, input int mode, input int exp_lat);
        int cyc, lat, beat;
        logic [31:0] ed;
        logic [1:0]  er;
        rsel = sel;
        arid = id; araddr = addr[31:0]; arlen = len[7:0]; arsize = size[2:0]; arburst = burst[1:0];
        arv = 1'b1; rrdy = 1'b0;
        cyc = 0;
        while (!o_arready && cyc < 100) begin tick(); cyc++; end
        chk("ar_timeout", 32'(cyc >= 100), 32'd0);
        tick();
        arv = 1'b0;
        lat = 1;
        while (!o_rvalid && lat < 100) begin tick(); lat++; end
        chk("r_latency", 32'(lat), 32'(exp_lat));
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 400) begin
            if (mode == 1)      rrdy = ((cyc % 2) == 0);
            else if (mode == 2) rrdy = 1'b1;
            else                rrdy = 1'($urandom_range(0, 1));
            if (mode == 2 && !sel) chk("r_b2b", 32'(o_rvalid), 32'd1);
            if (o_rvalid) begin
                exp_beat(beat_addr(addr, beat, size, burst), size, ed, er);
                chk("rdata", o_rdata, ed);
                chk("rresp", 32'(o_rresp), 32'(er));
                chk("rlast", 32'(o_rlast), 32'(beat == len));
                chk("rid", 32'(o_rid), 32'(id));
                chk("ar_busy", 32'(o_arready), 32'd0);
                if (rrdy) beat++;
            end
            tick();
            cyc++;
        end
        rrdy = 1'b0;
        chk("r_timeout", 32'(cyc >= 400), 32'd0);
        chk("ar_after_last", 32'(o_arready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, size, burst, li, off, r;
        longint a;

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_arready", 32'(arready0), 32'd0);
        chk("rst_awready", 32'(awready0), 32'd0);
        chk("rst_wready",  32'(wready0),  32'd0);
        chk("rst_rvalid",  32'(rvalid0),  32'd0);
        chk("rst_rlast",   32'(rlast0),   32'd0);
        chk("rst_bvalid",  32'(bvalid0),  32'd0);
        chk("rst_rid",     32'(rid0),     32'd0);
        chk("rst_bid",     32'(bid0),     32'd0);
        chk("rst_rresp",   32'(rresp0),   32'd0);
        chk("rst_bresp",   32'(bresp0),   32'd0);
        chk("rst_rdata",   rdata0,        32'd0);
        rst = 1'b0;
        tick(); tick();
        chk("idle_arready", 32'(arready0), 32'd1);
        chk("idle_awready", 32'(awready0), 32'd1);

        // Fill the whole array with 16-beat INCR bursts of random data
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
            do_write(longint'(BASE) + k * 64, 15, 2, 1, 15, 4'(k));
        end

        // Write then read one word
        wbuf_d[0] = 32'hDEAD_BEEF; wbuf_s[0] = 4'hF;
        do_write(longint'(BASE) + 32'h10, 0, 2, 1, 0, 4'h3);
        do_read(1'b0, longint'(BASE) + 32'h10, 0, 2, 1, 4'h9, 2, 1);

        // Byte strobes over a preloaded word
        wbuf_d[0] = 32'h1122_3344; wbuf_s[0] = 4'hF;
        do_write(longint'(BASE) + 32'h20, 0, 2, 1, 0, 4'h1);
        wbuf_d[0] = 32'hAABB_CCDD; wbuf_s[0] = 4'b0101;
        do_write(longint'(BASE) + 32'h20, 0, 2, 1, 0, 4'h2);
        do_read(1'b0, longint'(BASE) + 32'h20, 0, 2, 1, 4'h4, 2, 1);

        // INCR burst read under an alternating rready
        do_read(1'b0, longint'(BASE), 3, 2, 1, 4'h5, 1, 1);

        // Decode errors on reads just past the top and just below the base
        do_read(1'b0, longint'(BASE) + 4 * MW, 0, 2, 1, 4'h6, 2, 1);
        do_read(1'b0, longint'(BASE) - 4, 0, 2, 1, 4'h7, 2, 1);
        // INCR burst running off the end mixes OKAY and DECERR beats
        do_read(1'b0, longint'(BASE) + 4 * MW - 8, 3, 2, 1, 4'h8, 0, 1);

        // Early wlast: awlen=2, wlast on the second beat, third word untouched
        for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
        do_write(longint'(BASE) + 32'h100, 2, 2, 1, 1, 4'hA);
        do_read(1'b0, longint'(BASE) + 32'h100, 2, 2, 1, 4'hA, 2, 1);
        // Late wlast: beats past awlen are dropped
        for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
        do_write(longint'(BASE) + 32'h140, 1, 2, 1, 3, 4'hB);
        do_read(1'b0, longint'(BASE) + 32'h140, 3, 2, 1, 4'hB, 2, 1);
        // Oversized beats: no write, SLVERR on both channels
        for (int i = 0; i < 2; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
        do_write(longint'(BASE) + 32'h180, 1, 3, 1, 1, 4'hC);
        do_read(1'b0, longint'(BASE) + 32'h180, 1, 3, 1, 4'hC, 2, 1);
        do_read(1'b0, longint'(BASE) + 32'h180, 1, 2, 1, 4'hC, 2, 1);
        // Write burst crossing the top: first beat lands, second gives DECERR
        for (int i = 0; i < 2; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
        do_write(longint'(BASE) + 4 * MW - 4, 1, 2, 1, 1, 4'hD);
        do_read(1'b0, longint'(BASE) + 4 * MW - 4, 0, 2, 1, 4'hD, 2, 1);

        // Randomized writes, each read back with random burst shape and stalls
        for (int t = 0; t < 12; t++) begin
            size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            len   = int'($urandom_range(0, 7));
            burst = int'($urandom_range(0, 2));
            r     = int'($urandom_range(0, 5));
            li    = (r == 0) ? ((len > 0) ? len - 1 : len + 1) : ((r == 1) ? len + 2 : len);
            off   = int'($urandom_range(0, 4 * MW - 1)) & ~((1 << size) - 1);
            a     = longint'(BASE) + off;
            for (int i = 0; i < 16; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'($urandom_range(0, 15)); end
            do_write(a, len, size, burst, li, 4'($urandom_range(0, 15)));
            do_read(1'b0, a, len, (size > 2) ? 2 : size, burst, 4'($urandom_range(0, 15)), 0, 1);
        end

        // READ_DELAY=3 instance: single read and a burst with gaps
        do_read(1'b1, longint'(BASE) + 32'h10, 0, 2, 1, 4'h2, 2, 4);
        do_read(1'b1, longint'(BASE), 3, 2, 1, 4'h3, 0, 4);
        rsel = 1'b0;

        // Reset in the middle of an 8-beat read, then a fresh AR
        arid = 4'h6; araddr = BASE; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arv = 1'b1;
        r = 0;
        while (!arready0 && r < 100) begin tick(); r++; end
        chk("mid_ar_timeout", 32'(r >= 100), 32'd0);
        tick();
        arv = 1'b0; rrdy = 1'b1;
        tick(); tick();
        chk("mid_beat2_valid", 32'(rvalid0), 32'd1);
        chk("mid_beat2_data", rdata0, model[2]);
        rst = 1'b1;
        tick();
        rrdy = 1'b0;
        chk("mid_rst_rvalid", 32'(rvalid0), 32'd0);
        chk("mid_rst_arready", 32'(arready0), 32'd0);
        tick();
        chk("mid_rst_arready_hold", 32'(arready0), 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_after_arready", 32'(arready0), 32'd1);
        chk("mid_after_rvalid", 32'(rvalid0), 32'd0);
        do_read(1'b0, longint'(BASE) + 32'h40, 3, 2, 1, 4'hE, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
